// File: rtl/dram_arb_pkg.sv
// dram_arb_pkg
//   Shared definitions for the two-client DRAM arbiter.
//   arb_state_t : arbiter FSM encoding (also exported on the debug port)
//   CLIENT0/1   : client id values carried in the grant id
package dram_arb_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } arb_state_t;

   localparam logic CLIENT0 = 1'b0;
   localparam logic CLIENT1 = 1'b1;

endpackage

// File: rtl/dram_arbiter_rr_arb2.sv
// rr_arb2
//   Combinational two-way round-robin pick.
//   req[1:0]  : request per client
//   last      : id of the most recently granted client
//   gnt_valid : at least one request is present
//   gnt_id    : chosen client (the one that is not 'last' on a tie)
module rr_arb2
   import dram_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       gnt_valid,
   output logic       gnt_id
);

   always_comb begin
      gnt_valid = |req;
      gnt_id    = CLIENT0;
      case (req)
         2'b01:   gnt_id = CLIENT0;
         2'b10:   gnt_id = CLIENT1;
         2'b11:   gnt_id = ~last;
         default: gnt_id = CLIENT0;
      endcase
   end

endmodule

// File: rtl/dram_arbiter.sv
// dram_arbiter
//   Shares one byte-wide DRAM controller between two clients, one access at
//   a time, with round-robin fairness and an ack timeout.
//   clk, rst_n                 : clock, synchronous active-low reset
//   cN_req/write/addr/wr_data  : client N request and fields
//   cN_ack, cN_done            : one-cycle accept / completion pulses
//   cN_rd_data                 : per-client read byte, held until next done
//   m_ena/write/addr/wr_data   : controller strobe and request fields
//   m_ack, m_busy, m_rd_data   : controller accept, busy and read data
//   err                        : sticky ack-timeout flag
//   dbg_state                  : current FSM state
//
// Handshake: a client raises cN_req with stable fields and holds both until
// it sees cN_ack; fields are latched in that grant cycle and the client is
// free afterwards. cN_done later marks completion of that same access.
// Towards the controller, m_ena with stable fields is held until m_ack; the
// access is finished once m_busy is low in the cycles after m_ack.
module dram_arbiter
   import dram_arb_pkg::*;
#(
   parameter int AW          = 24,
   parameter int DW          = 8,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          c0_req,
   input  logic          c0_write,
   input  logic [AW-1:0] c0_addr,
   input  logic [DW-1:0] c0_wr_data,
   output logic          c0_ack,
   output logic          c0_done,
   output logic [DW-1:0] c0_rd_data,
   input  logic          c1_req,
   input  logic          c1_write,
   input  logic [AW-1:0] c1_addr,
   input  logic [DW-1:0] c1_wr_data,
   output logic          c1_ack,
   output logic          c1_done,
   output logic [DW-1:0] c1_rd_data,
   output logic          m_ena,
   output logic          m_write,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wr_data,
   input  logic          m_ack,
   input  logic          m_busy,
   input  logic [DW-1:0] m_rd_data,
   output logic          err,
   output arb_state_t    dbg_state
);

   localparam int            TW      = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_MAX = TW'(ACK_TIMEOUT);

   arb_state_t    state_q, state_d;
   logic          last_q, last_d;
   logic          gnt_id_q, gnt_id_d;
   logic          m_ena_q, m_ena_d;
   logic          m_write_q, m_write_d;
   logic [AW-1:0] m_addr_q, m_addr_d;
   logic [DW-1:0] m_wr_data_q, m_wr_data_d;
   logic          c0_ack_q, c0_ack_d, c1_ack_q, c1_ack_d;
   logic          c0_done_q, c0_done_d, c1_done_q, c1_done_d;
   logic [DW-1:0] c0_rd_q, c0_rd_d, c1_rd_q, c1_rd_d;
   logic          err_q, err_d;
   logic [TW-1:0] tmo_q, tmo_d, tmo_inc;

   logic          gnt_valid;
   logic          gnt_id;

   rr_arb2 u_rr (
      .req       ({c1_req, c0_req}),
      .last      (last_q),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id)
   );

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      gnt_id_d    = gnt_id_q;
      m_ena_d     = m_ena_q;
      m_write_d   = m_write_q;
      m_addr_d    = m_addr_q;
      m_wr_data_d = m_wr_data_q;
      c0_ack_d    = 1'b0;
      c1_ack_d    = 1'b0;
      c0_done_d   = 1'b0;
      c1_done_d   = 1'b0;
      c0_rd_d     = c0_rd_q;
      c1_rd_d     = c1_rd_q;
      err_d       = err_q;
      tmo_d       = tmo_q;
      // Saturating increment: the counter parks at its maximum, never wraps.
      tmo_inc     = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;

      case (state_q)
         S_IDLE: begin
            // Holding off while the controller is busy also covers its
            // power-up init and an access left running across a reset.
            if (gnt_valid && !m_busy) begin
               gnt_id_d = gnt_id;
               last_d   = gnt_id;
               tmo_d    = '0;
               m_ena_d  = 1'b1;
               state_d  = S_ISSUE;
               if (gnt_id == CLIENT1) begin
                  m_write_d   = c1_write;
                  m_addr_d    = c1_addr;
                  m_wr_data_d = c1_wr_data;
                  c1_ack_d    = 1'b1;
               end else begin
                  m_write_d   = c0_write;
                  m_addr_d    = c0_addr;
                  m_wr_data_d = c0_wr_data;
                  c0_ack_d    = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            if (m_ack) begin
               m_ena_d = 1'b0;
               state_d = S_WAIT;
            end else begin
               tmo_d = tmo_inc;
               // m_ena has then been high for ACK_TIMEOUT cycles.
               if (tmo_inc == TMO_MAX) begin
                  m_ena_d = 1'b0;
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_WAIT: begin
            if (!m_busy) begin
               if (!m_write_q) begin
                  if (gnt_id_q == CLIENT1) c1_rd_d = m_rd_data;
                  else                     c0_rd_d = m_rd_data;
               end
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            // First cycle raises the done pulse, second cycle (pulse visible)
            // returns to idle.
            if (c0_done_q || c1_done_q) begin
               state_d = S_IDLE;
            end else if (gnt_id_q == CLIENT1) begin
               c1_done_d = 1'b1;
            end else begin
               c0_done_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         last_q      <= CLIENT1;
         gnt_id_q    <= CLIENT0;
         m_ena_q     <= 1'b0;
         m_write_q   <= 1'b0;
         m_addr_q    <= '0;
         m_wr_data_q <= '0;
         c0_ack_q    <= 1'b0;
         c1_ack_q    <= 1'b0;
         c0_done_q   <= 1'b0;
         c1_done_q   <= 1'b0;
         c0_rd_q     <= '0;
         c1_rd_q     <= '0;
         err_q       <= 1'b0;
         tmo_q       <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         gnt_id_q    <= gnt_id_d;
         m_ena_q     <= m_ena_d;
         m_write_q   <= m_write_d;
         m_addr_q    <= m_addr_d;
         m_wr_data_q <= m_wr_data_d;
         c0_ack_q    <= c0_ack_d;
         c1_ack_q    <= c1_ack_d;
         c0_done_q   <= c0_done_d;
         c1_done_q   <= c1_done_d;
         c0_rd_q     <= c0_rd_d;
         c1_rd_q     <= c1_rd_d;
         err_q       <= err_d;
         tmo_q       <= tmo_d;
      end
   end

   assign c0_ack     = c0_ack_q;
   assign c1_ack     = c1_ack_q;
   assign c0_done    = c0_done_q;
   assign c1_done    = c1_done_q;
   assign c0_rd_data = c0_rd_q;
   assign c1_rd_data = c1_rd_q;
   assign m_ena      = m_ena_q;
   assign m_write    = m_write_q;
   assign m_addr     = m_addr_q;
   assign m_wr_data  = m_wr_data_q;
   assign err        = err_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_dram_arbiter.sv
module tb_dram_arbiter;
   import dram_arb_pkg::*;

   localparam int AW  = 24;
   localparam int DW  = 8;
   localparam int TMO = 8;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic          c0_req = 1'b0, c0_write = 1'b0;
   logic [AW-1:0] c0_addr = '0;
   logic [DW-1:0] c0_wr_data = '0;
   logic          c0_ack, c0_done;
   logic [DW-1:0] c0_rd_data;
   logic          c1_req = 1'b0, c1_write = 1'b0;
   logic [AW-1:0] c1_addr = '0;
   logic [DW-1:0] c1_wr_data = '0;
   logic          c1_ack, c1_done;
   logic [DW-1:0] c1_rd_data;
   logic          m_ena, m_write;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wr_data;
   logic          m_ack = 1'b0, m_busy = 1'b0;
   logic [DW-1:0] m_rd_data = '0;
   logic          err;
   arb_state_t    dbg_state;

   dram_arbiter #(.AW(AW), .DW(DW), .ACK_TIMEOUT(TMO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .c0_req     (c0_req),
      .c0_write   (c0_write),
      .c0_addr    (c0_addr),
      .c0_wr_data (c0_wr_data),
      .c0_ack     (c0_ack),
      .c0_done    (c0_done),
      .c0_rd_data (c0_rd_data),
      .c1_req     (c1_req),
      .c1_write   (c1_write),
      .c1_addr    (c1_addr),
      .c1_wr_data (c1_wr_data),
      .c1_ack     (c1_ack),
      .c1_done    (c1_done),
      .c1_rd_data (c1_rd_data),
      .m_ena      (m_ena),
      .m_write    (m_write),
      .m_addr     (m_addr),
      .m_wr_data  (m_wr_data),
      .m_ack      (m_ack),
      .m_busy     (m_busy),
      .m_rd_data  (m_rd_data),
      .err        (err),
      .dbg_state  (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int total = 0;
   int bad   = 0;
   // grant entry: {id, write, addr[23:0], wr_data[7:0]}
   logic [33:0] gnt_q[$];
   // done entry: {id, rd_data[7:0]}
   logic [8:0]  exp_q[$];
   logic [33:0] cur_gnt, ge;
   logic [8:0]  de;
   bit          issue_active = 1'b0;
   int          ack_cyc = 0;
   int          c1_ack_cnt = 0, c1_done_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- controller model ----------------
   int  init_busy = 0;
   bit  init_active = 1'b0;
   int  fall_cyc = -1;
   int  ack_delay = 0;
   int  busy_len = 3;
   bit  ack_never = 1'b0;
   int  mdl_cnt = 0, mdl_bcnt = 0;
   bit  mdl_busy_ph = 1'b0;
   logic [7:0] mem [logic [23:0]];

   initial begin : ctrl_model
      forever begin
         @(negedge clk);
         m_ack = 1'b0;
         if (init_busy > 0) begin
            m_busy = 1'b1;
            init_busy--;
            init_active = 1'b1;
         end else if (init_active) begin
            m_busy      = 1'b0;
            init_active = 1'b0;
            fall_cyc    = cyc;
         end else if (mdl_busy_ph) begin
            mdl_bcnt--;
            if (mdl_bcnt == 0) begin
               m_busy      = 1'b0;
               mdl_busy_ph = 1'b0;
            end
         end else if (m_ena && !ack_never) begin
            if (mdl_cnt == ack_delay) begin
               m_ack       = 1'b1;
               m_busy      = 1'b1;
               mdl_busy_ph = 1'b1;
               mdl_bcnt    = busy_len;
               mdl_cnt     = 0;
               if (m_write) mem[m_addr] = m_wr_data;
               else m_rd_data = mem.exists(m_addr) ? mem[m_addr] : (m_addr[7:0] ^ 8'h3C);
            end else begin
               mdl_cnt++;
            end
         end else begin
            mdl_cnt = 0;
         end
      end
   end

   // ---------------- monitor ----------------
   initial begin : monitor
      forever begin
         @(posedge clk);
         #1;
         if (c0_ack && c1_ack) begin
            total++; bad++;
            $display("FAIL dual_ack: got both acks expected one");
         end
         if (c0_ack || c1_ack) begin
            ack_cyc = cyc;
            if (c1_ack) c1_ack_cnt++;
            if (gnt_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_ack: got ack c1=%0b expected none", c1_ack);
            end else begin
               ge = gnt_q.pop_front();
               check("gnt_id", 64'(c1_ack), 64'(ge[33]));
               check("gnt_m_ena", 64'(m_ena), 64'd1);
               check("gnt_m_write", 64'(m_write), 64'(ge[32]));
               check("gnt_m_addr", 64'(m_addr), 64'(ge[31:8]));
               check("gnt_m_wr_data", 64'(m_wr_data), 64'(ge[7:0]));
               cur_gnt      = ge;
               issue_active = 1'b1;
            end
         end else if (issue_active) begin
            if (!m_ena) begin
               issue_active = 1'b0;
            end else begin
               check("issue_addr_stable", 64'(m_addr), 64'(cur_gnt[31:8]));
               check("issue_data_stable", 64'(m_wr_data), 64'(cur_gnt[7:0]));
            end
         end
         if (c0_done && c1_done) begin
            total++; bad++;
            $display("FAIL dual_done: got both dones expected one");
         end
         if (c0_done || c1_done) begin
            if (c1_done) c1_done_cnt++;
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_done: got done c1=%0b expected none", c1_done);
            end else begin
               de = exp_q.pop_front();
               check("done_client", 64'(c1_done), 64'(de[8]));
               check("done_rd_data", 64'(c1_done ? c1_rd_data : c0_rd_data), 64'(de[7:0]));
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic issue(input int c, input bit wr, input logic [23:0] a, input logic [7:0] d,
                        input bit keep);
      int n;
      @(negedge clk);
      if (c == 0) begin
         c0_write = wr; c0_addr = a; c0_wr_data = d; c0_req = 1'b1;
      end else begin
         c1_write = wr; c1_addr = a; c1_wr_data = d; c1_req = 1'b1;
      end
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!(c == 0 ? c0_ack : c1_ack) && n < 300);
      if (!(c == 0 ? c0_ack : c1_ack)) begin
         total++; bad++;
         $display("FAIL ack_wait client=%0d: got no ack expected ack within 300 cycles", c);
      end
      if (!keep) begin
         @(negedge clk);
         if (c == 0) c0_req = 1'b0;
         else        c1_req = 1'b0;
      end
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || gnt_q.size() != 0 || dbg_state != S_IDLE) && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      check(name, 64'(exp_q.size() + gnt_q.size()), 64'd0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin : main
      int n;
      int a0, d0;

      // controller stays busy through reset and ~20 cycles beyond
      init_busy = 23;
      rst_n     = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
      check("rst_m_ena", 64'(m_ena), 64'd0);
      check("rst_m_write", 64'(m_write), 64'd0);
      check("rst_m_addr", 64'(m_addr), 64'd0);
      check("rst_m_wr_data", 64'(m_wr_data), 64'd0);
      check("rst_c0_ack", 64'(c0_ack), 64'd0);
      check("rst_c1_ack", 64'(c1_ack), 64'd0);
      check("rst_c0_done", 64'(c0_done), 64'd0);
      check("rst_c1_done", 64'(c1_done), 64'd0);
      check("rst_c0_rd_data", 64'(c0_rd_data), 64'd0);
      check("rst_c1_rd_data", 64'(c1_rd_data), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_state", 64'(dbg_state), 64'(S_IDLE));
      @(negedge clk);
      rst_n = 1'b1;

      // 1: request during controller init busy; grant only after busy falls
      @(negedge clk);
      gnt_q.push_back({1'b0, 1'b0, 24'h000010, 8'h00});
      exp_q.push_back({1'b0, 8'h2C});
      issue(0, 1'b0, 24'h000010, 8'h00, 1'b0);
      check("init_busy_ack_cycle", 64'(ack_cyc), 64'(fall_cyc + 1));
      wait_drain("drain_init_read");

      // 2: c0 writes A5, c1 reads it back; c0 read data untouched
      apply_reset();
      gnt_q.push_back({1'b0, 1'b1, 24'h000100, 8'hA5});
      exp_q.push_back({1'b0, 8'h00});
      issue(0, 1'b1, 24'h000100, 8'hA5, 1'b0);
      gnt_q.push_back({1'b1, 1'b0, 24'h000100, 8'h00});
      exp_q.push_back({1'b1, 8'hA5});
      issue(1, 1'b0, 24'h000100, 8'h00, 1'b0);
      wait_drain("drain_write_read");
      check("c0_rd_data_after_write", 64'(c0_rd_data), 64'd0);

      // 3: both clients hold requests for three accesses each
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         gnt_q.push_back({1'b0, 1'b1, 24'(24'h000200 + i), 8'(8'h10 + i)});
         exp_q.push_back({1'b0, 8'h00});
         gnt_q.push_back({1'b1, 1'b0, 24'(24'h000300 + i), 8'h00});
         exp_q.push_back({1'b1, 8'(8'h3C + i)});
      end
      fork
         begin
            for (int i = 0; i < 3; i++)
               issue(0, 1'b1, 24'(24'h000200 + i), 8'(8'h10 + i), i < 2);
         end
         begin
            for (int i = 0; i < 3; i++)
               issue(1, 1'b0, 24'(24'h000300 + i), 8'h00, i < 2);
         end
      join
      wait_drain("drain_round_robin");

      // 4: slow controller ack; fields must stay put, single ack/done
      ack_delay = 4;
      a0 = c1_ack_cnt;
      d0 = c1_done_cnt;
      gnt_q.push_back({1'b1, 1'b1, 24'h123456, 8'h77});
      exp_q.push_back({1'b1, 8'h3E});
      issue(1, 1'b1, 24'h123456, 8'h77, 1'b0);
      wait_drain("drain_slow_ack");
      check("slow_ack_c1_ack_count", 64'(c1_ack_cnt - a0), 64'd1);
      check("slow_ack_c1_done_count", 64'(c1_done_cnt - d0), 64'd1);
      ack_delay = 0;

      // 5: reset while waiting on busy; no done, then reissue completes
      busy_len = 6;
      gnt_q.push_back({1'b0, 1'b0, 24'h000040, 8'h00});
      issue(0, 1'b0, 24'h000040, 8'h00, 1'b0);
      n = 0;
      while (dbg_state != S_WAIT && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("reached_wait", 64'(dbg_state), 64'(S_WAIT));
      busy_len = 3;
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_m_ena", 64'(m_ena), 64'd0);
      check("midrst_err", 64'(err), 64'd0);
      check("midrst_c0_done", 64'(c0_done), 64'd0);
      check("midrst_state", 64'(dbg_state), 64'(S_IDLE));
      @(negedge clk);
      rst_n = 1'b1;
      gnt_q.push_back({1'b0, 1'b0, 24'h000040, 8'h00});
      exp_q.push_back({1'b0, 8'h7C});
      issue(0, 1'b0, 24'h000040, 8'h00, 1'b0);
      wait_drain("drain_reissue");

      // 6: controller never acks; abort after TMO cycles of m_ena
      ack_never = 1'b1;
      gnt_q.push_back({1'b0, 1'b0, 24'h000055, 8'h00});
      exp_q.push_back({1'b0, 8'h7C});
      issue(0, 1'b0, 24'h000055, 8'h00, 1'b0);
      n = 1;
      forever begin
         @(posedge clk);
         #1;
         if (!m_ena || n >= 50) break;
         n++;
      end
      check("timeout_m_ena_cycles", 64'(n), 64'(TMO));
      check("timeout_err", 64'(err), 64'd1);
      wait_drain("drain_timeout");
      check("timeout_err_sticky", 64'(err), 64'd1);
      ack_never = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
